// File: rtl/shifter_palette.sv
// Purpose: 16-entry colour palette with CPU read/write port and pixel colour lookup (low/medium/mono).
// Latency: CPU read data 1 clk32 after address; colour/mono outputs 1 pixClkEn edge after index.
// Backpressure: none; bus accesses are never stalled and the pixel path advances only on pixClkEn.
//
// Ports:
//   clk32, nReset             clock, async active-low reset
//   pixClkEn                  pixel-rate enable (one clk32 wide)
//   rez, color_index, DE,     resolution, pixel index, display enable,
//   BLANK_N                   blanking (0 = black)
//   nCS, RW, nUDS, nLDS, A,   CPU palette register access
//   DIN, DOUT                 CPU write / registered read data
//   R, G, B, MONO             video outputs
module shifter_palette #(
    parameter int STE = 1
) (
    input  logic        clk32,
    input  logic        nReset,
    input  logic        pixClkEn,
    input  logic [1:0]  rez,
    input  logic [3:0]  color_index,
    input  logic        DE,
    input  logic        BLANK_N,
    input  logic        nCS,
    input  logic        RW,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic [3:0]  A,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        MONO
);

    logic [11:0] r_pal [16];
    logic        r_wr_prev;
    logic [11:0] r_rgb;
    logic        r_mono;
    logic [15:0] r_dout;

    logic        w_wr_cond;
    logic        w_commit;
    logic [11:0] w_din_m;
    logic [3:0]  w_idx;
    logic        w_mono_bit;
    logic        w_unused;

    // The upper nibble of the CPU word has no storage behind it.
    assign w_unused = ^DIN[15:12];

    assign w_wr_cond = ~nCS & ~RW & (~nUDS | ~nLDS);
    // Commit only on the rising edge of the write condition so held strobes write once.
    assign w_commit  = w_wr_cond & ~r_wr_prev;

    // The 9-bit palette has no storage for the top bit of each gun.
    assign w_din_m = (STE != 0) ? DIN[11:0] : (DIN[11:0] & 12'h777);

    always_comb begin
        w_idx = color_index;
        if (rez == 2'd1) begin
            w_idx = {2'b00, color_index[1:0]};
        end
        if (!DE) begin
            w_idx = 4'h0;
        end
    end

    assign w_mono_bit = BLANK_N & DE & ~(color_index[0] ^ r_pal[0][0]);

    // Edge detector resets to "condition seen true": a strobe held across reset
    // must go inactive once before it can commit again.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_wr_prev <= 1'b1;
        end else begin
            r_wr_prev <= w_wr_cond;
        end
    end

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < 16; i++) begin
                r_pal[i] <= 12'h000;
            end
        end else if (w_commit) begin
            if (!nUDS) begin
                r_pal[A][11:8] <= w_din_m[11:8];
            end
            if (!nLDS) begin
                r_pal[A][7:0] <= w_din_m[7:0];
            end
        end
    end

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_dout <= 16'h0000;
        end else if (!nCS && RW) begin
            r_dout <= {4'h0, r_pal[A]};
        end else begin
            r_dout <= 16'h0000;
        end
    end

    // Lookup reads the palette before any same-edge write lands.
    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            r_rgb  <= 12'h000;
            r_mono <= 1'b0;
        end else if (pixClkEn) begin
            if (rez == 2'd2) begin
                r_mono <= w_mono_bit;
                r_rgb  <= {12{w_mono_bit}};
            end else begin
                r_mono <= 1'b0;
                r_rgb  <= BLANK_N ? r_pal[w_idx] : 12'h000;
            end
        end
    end

    assign DOUT = r_dout;
    assign R    = r_rgb[11:8];
    assign G    = r_rgb[7:4];
    assign B    = r_rgb[3:0];
    assign MONO = r_mono;

endmodule

// File: tb/tb_shifter_palette.sv
// Purpose: self-checking bench for shifter_palette (STE=1 and STE=0 instances on shared inputs).
// Latency: checks taken on the falling edge after each rising edge of clk32.
// Backpressure: not applicable; stimulus is driven freely on the falling edge.
module tb_shifter_palette;

    logic        clk32, nReset, pixClkEn;
    logic [1:0]  rez;
    logic [3:0]  color_index;
    logic        DE, BLANK_N, nCS, RW, nUDS, nLDS;
    logic [3:0]  A;
    logic [15:0] DIN;
    logic [15:0] dout_e, dout_s;
    logic [3:0]  r_e, g_e, b_e, r_s, g_s, b_s;
    logic        mono_e, mono_s;

    int n_tests = 0;
    int n_fail  = 0;

    shifter_palette #(.STE(1)) u_ste (
        .clk32(clk32), .nReset(nReset), .pixClkEn(pixClkEn), .rez(rez),
        .color_index(color_index), .DE(DE), .BLANK_N(BLANK_N), .nCS(nCS), .RW(RW),
        .nUDS(nUDS), .nLDS(nLDS), .A(A), .DIN(DIN), .DOUT(dout_e),
        .R(r_e), .G(g_e), .B(b_e), .MONO(mono_e)
    );

    shifter_palette #(.STE(0)) u_st (
        .clk32(clk32), .nReset(nReset), .pixClkEn(pixClkEn), .rez(rez),
        .color_index(color_index), .DE(DE), .BLANK_N(BLANK_N), .nCS(nCS), .RW(RW),
        .nUDS(nUDS), .nLDS(nLDS), .A(A), .DIN(DIN), .DOUT(dout_s),
        .R(r_s), .G(g_s), .B(b_s), .MONO(mono_s)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    // Scoreboard: kind 0 = STE DOUT, 1 = STE {R,G,B}, 2 = STE MONO, 3 = ST DOUT
    typedef struct {
        string       nm;
        int          kind;
        logic [15:0] val;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [1:0]  rez;
        logic [3:0]  ci;
        logic        de;
        logic        blank;
        logic [11:0] rgb;
        logic        mono;
    } vec_t;
    vec_t vt[12];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk32);
        @(negedge clk32);
    endtask

    task automatic push(input string nm, input int kind, input logic [15:0] val);
        sb_t e;
        e.nm = nm; e.kind = kind; e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        logic [15:0] act;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       act = dout_e;
                1:       act = {4'h0, r_e, g_e, b_e};
                2:       act = {15'h0, mono_e};
                default: act = dout_s;
            endcase
            check(e.nm, act, e.val);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic u, input logic l);
        A = a; DIN = d; RW = 1'b0; nCS = 1'b0; nUDS = ~u; nLDS = ~l;
        tick();
        nCS = 1'b1; RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        tick();
    endtask

    task automatic rd(input string nm, input logic [3:0] a, input int kind, input logic [15:0] exp);
        A = a; nCS = 1'b0; RW = 1'b1;
        push(nm, kind, exp);
        tick();
        drain();
        nCS = 1'b1;
    endtask

    task automatic pix(input string nm, input logic [1:0] rz, input logic [3:0] ci, input logic de,
                       input logic bl, input logic [11:0] rgb, input logic mono);
        rez = rz; color_index = ci; DE = de; BLANK_N = bl; pixClkEn = 1'b1;
        push({nm, "_rgb"}, 1, {4'h0, rgb});
        push({nm, "_mono"}, 2, {15'h0, mono});
        tick();
        pixClkEn = 1'b0;
        drain();
    endtask

    initial begin
        // Palette for table: entry0=0A0 (bit0=0), entry1=111, entry2=DBC, entry9=456
        vt[0]  = '{2'd0, 4'd9, 1'b1, 1'b1, 12'h456, 1'b0};
        vt[1]  = '{2'd3, 4'd9, 1'b1, 1'b1, 12'h456, 1'b0};
        vt[2]  = '{2'd0, 4'd9, 1'b0, 1'b1, 12'h0A0, 1'b0};
        vt[3]  = '{2'd0, 4'd9, 1'b1, 1'b0, 12'h000, 1'b0};
        vt[4]  = '{2'd1, 4'd9, 1'b1, 1'b1, 12'h111, 1'b0};
        vt[5]  = '{2'd2, 4'd0, 1'b1, 1'b1, 12'hFFF, 1'b1};
        vt[6]  = '{2'd2, 4'd1, 1'b1, 1'b1, 12'h000, 1'b0};
        vt[7]  = '{2'd2, 4'd0, 1'b0, 1'b1, 12'h000, 1'b0};
        vt[8]  = '{2'd1, 4'd6, 1'b1, 1'b1, 12'hDBC, 1'b0};
        // After entry0 becomes 0A1 the mono sense inverts
        vt[9]  = '{2'd2, 4'd1, 1'b1, 1'b1, 12'hFFF, 1'b1};
        vt[10] = '{2'd2, 4'd0, 1'b1, 1'b1, 12'h000, 1'b0};
        vt[11] = '{2'd0, 4'd9, 1'b0, 1'b1, 12'h0A1, 1'b0};

        nReset = 1'b0; pixClkEn = 1'b0; rez = 2'd0; color_index = 4'h0;
        DE = 1'b1; BLANK_N = 1'b1; nCS = 1'b1; RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        A = 4'h0; DIN = 16'h0000;
        repeat (3) tick();
        check("rst_dout", dout_e, 16'h0000);
        check("rst_rgb", {4'h0, r_e, g_e, b_e}, 16'h0000);
        check("rst_mono", {15'h0, mono_e}, 16'h0000);
        nReset = 1'b1;
        repeat (2) tick();
        rd("rst_entry7", 4'd7, 0, 16'h0000);

        // 12-bit vs 9-bit storage
        bus_write(4'd5, 16'hF777, 1'b1, 1'b1);
        rd("ste_f777", 4'd5, 0, 16'h0777);
        rd("st_f777", 4'd5, 3, 16'h0777);
        bus_write(4'd5, 16'h0FFF, 1'b1, 1'b1);
        rd("ste_0fff", 4'd5, 0, 16'h0FFF);
        rd("st_0fff", 4'd5, 3, 16'h0777);
        tick();
        check("dout_idle", dout_e, 16'h0000);

        // Byte lanes
        bus_write(4'd2, 16'h0123, 1'b1, 1'b1);
        bus_write(4'd2, 16'h0ABC, 1'b0, 1'b1);
        rd("lane_lds", 4'd2, 0, 16'h01BC);
        bus_write(4'd2, 16'h0D00, 1'b1, 1'b0);
        rd("lane_uds", 4'd2, 0, 16'h0DBC);

        // Read on the clk32 right after the commit
        A = 4'd6; DIN = 16'h0C3A; nCS = 1'b0; RW = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        tick();
        RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        push("raw_next", 0, 16'h0C3A);
        tick();
        drain();
        nCS = 1'b1;
        tick();

        bus_write(4'd0, 16'h00A0, 1'b1, 1'b1);
        bus_write(4'd1, 16'h0111, 1'b1, 1'b1);
        bus_write(4'd9, 16'h0456, 1'b1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            pix($sformatf("vec%0d", i), vt[i].rez, vt[i].ci, vt[i].de, vt[i].blank, vt[i].rgb, vt[i].mono);
        end
        bus_write(4'd0, 16'h00A1, 1'b1, 1'b1);
        for (int i = 9; i < 12; i++) begin
            pix($sformatf("vec%0d", i), vt[i].rez, vt[i].ci, vt[i].de, vt[i].blank, vt[i].rgb, vt[i].mono);
        end

        // Outputs hold without pixClkEn
        DE = 1'b1; rez = 2'd0; color_index = 4'd9;
        tick(); tick();
        check("hold_rgb", {4'h0, r_e, g_e, b_e}, 16'h00A1);

        // Same-edge write and lookup of entry 4
        bus_write(4'd4, 16'h0123, 1'b1, 1'b1);
        rez = 2'd0; color_index = 4'd4; DE = 1'b1; BLANK_N = 1'b1; pixClkEn = 1'b1;
        A = 4'd4; DIN = 16'h0321; nCS = 1'b0; RW = 1'b0; nUDS = 1'b0; nLDS = 1'b0;
        push("same_edge_old", 1, 16'h0123);
        tick();
        drain();
        nCS = 1'b1; RW = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        push("same_edge_new", 1, 16'h0321);
        tick();
        drain();
        pixClkEn = 1'b0;

        // Held low-byte strobe for 10 clk32 with changing data: only the first commits
        A = 4'd3; nCS = 1'b0; RW = 1'b0; nUDS = 1'b1; nLDS = 1'b0;
        for (int i = 0; i < 10; i++) begin
            DIN = {8'h00, 4'(i + 1), 4'(i + 1)};
            tick();
        end
        nCS = 1'b1; RW = 1'b1; nLDS = 1'b1;
        tick();
        rd("hold_once", 4'd3, 0, 16'h0011);

        // Reset pulsed in the middle of a held strobe
        A = 4'd3; DIN = 16'h0066; nCS = 1'b0; RW = 1'b0; nLDS = 1'b0;
        repeat (3) tick();
        #2 nReset = 1'b0;
        #1;
        check("midrst_rgb", {4'h0, r_e, g_e, b_e}, 16'h0000);
        check("midrst_dout", dout_e, 16'h0000);
        @(negedge clk32);
        nReset = 1'b1;
        DIN = 16'h0099;
        repeat (5) tick();
        nLDS = 1'b1;
        rd("midrst_nocommit", 4'd3, 0, 16'h0000);
        rd("midrst_entry5", 4'd5, 0, 16'h0000);
        rd("midrst_entry9", 4'd9, 0, 16'h0000);
        bus_write(4'd3, 16'h0077, 1'b0, 1'b1);
        rd("rearm_commit", 4'd3, 0, 16'h0077);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
